// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop line synchronizer and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT FIFO; otherwise a single holding register is used.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_clks
        $error("uart_rx: CLKS_PER_BIT must be at least 8");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      sync_q, sync_d;
    logic [1:0]      settle_q, settle_d;
    logic            armed_q, armed_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rx_s;
    logic            tick;
    logic            push;
    logic            pop;

    assign rx_s = sync_q[1];
    assign tick = (timer_q == T_LAST);
    assign pop  = o_valid & i_ready;

    // A start is only accepted after rx_s has been seen high on real line samples
    // (settle_q skips the reset-loaded synchronizer values), so a frame cut by
    // reset or a low line after a frame error is never mistaken for a start bit.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        sync_d      = {sync_q[0], rx};
        settle_d    = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                if (armed_q && !rx_s) begin
                    state_d = START;
                    armed_d = 1'b0;
                end else if ((settle_q == 2'd2) && rx_s) begin
                    armed_d = 1'b1;
                end
            end
            START: begin
                if (timer_q == T_MID) begin
                    timer_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sync_q      <= 2'b11;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   count_q, count_d;
    logic          full;
    logic          push_ok;

    assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);

    // A pop frees the head slot in the same cycle, so a push into a full FIFO
    // alongside a pop still lands; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q;
        overrun_d = 1'b0;
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_q] = shift_q;
            wr_d        = wr_q + 1'b1;
        end else if (push) begin
            overrun_d = 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_valid = (count_q != '0);
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    always_comb begin
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            if (!valid_q || pop) begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = hold_q;
    assign o_valid = valid_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, is the number of i_clk cycles per UART bit (minimum 8).
REQ-002 Parameter FIFO_DEPTH, default 4, is the receive buffer depth in bytes (power of 2, minimum 2); it is used only with UART_RX_FIFO_EN.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous UART serial line, idle high.
REQ-006 The block SHALL have port o_data, output, 8 bits: received byte at the head of the buffer.
REQ-007 The block SHALL have port o_valid, output, 1 bit: o_data holds an unconsumed byte.
REQ-008 The block SHALL have port i_ready, input, 1 bit: the consumer accepts o_data this cycle.
REQ-009 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 The block SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all line decisions use the synchronized value rx_s.
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, no parity.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-014 IDLE: a 1->0 transition on rx_s SHALL enter START and clear the bit-timer.
REQ-015 START: at timer = CLKS_PER_BIT/2-1 (mid-bit), rx_s=0 SHALL enter DATA; rx_s=1 is a false start and SHALL return to IDLE with no flag raised.
REQ-016 DATA: rx_s SHALL be sampled every CLKS_PER_BIT cycles after the mid-start point, shifting LSB first; after the 8th sample the FSM SHALL enter STOP.
REQ-017 STOP: rx_s SHALL be sampled CLKS_PER_BIT cycles after the last data sample.
REQ-018 A stop sample of 1 SHALL push the byte into the buffer.
REQ-019 A stop sample of 0 SHALL discard the byte and pulse o_frame_err.
REQ-020 The FSM SHALL return to IDLE in the cycle after the stop sample in both cases.
REQ-021 After a frame error, the next start SHALL be detected only on a fresh 1->0 edge.
REQ-022 Latency: o_valid SHALL rise in the cycle after the stop sample when the buffer was empty.
REQ-023 A transfer SHALL occur on a cycle where o_valid=1 and i_ready=1.
REQ-024 o_data SHALL be held stable while o_valid=1 and i_ready=0.
REQ-025 i_ready with o_valid=0 SHALL have no effect.
REQ-026 A push while the buffer is full and no pop occurs in the same cycle SHALL drop the new byte, keep the buffered data intact and pulse o_overrun.
REQ-027 A push and a pop in the same cycle while full SHALL both complete, with no overrun.
REQ-028 A push and a pop in the same cycle while holding one entry SHALL leave o_valid=1 with the new byte.
REQ-029 Buffer pointers SHALL wrap modulo the buffer depth.
REQ-030 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-031 While i_rst=0 at a rising edge, the block SHALL set: FSM = IDLE, timer = 0, buffer empty, o_valid=0, o_data=8'h00, o_frame_err=0, o_overrun=0, and both synchronizer flops = 1.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no flag; the remaining bits SHALL NOT be decoded as a new frame until a 1->0 edge follows an observed idle high.

Configuration
REQ-033 With macro UART_RX_FIFO_EN defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO with first-word fall-through; o_data SHALL equal the oldest entry.
REQ-034 Without UART_RX_FIFO_EN, the buffer SHALL be a single holding register (depth 1), and the full/overrun rules of REQ-026 to REQ-028 SHALL apply at depth 1.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-035 Case 1: send 8'hA5 with i_ready=0 -> o_valid rises 1 cycle after the stop sample, o_data=8'hA5 held; assert i_ready for 1 cycle -> o_valid=0.
REQ-036 Case 2: 4-cycle low glitch on idle rx -> FSM returns to IDLE, o_valid=0, no o_frame_err.
REQ-037 Case 3: send 8'h3C with the stop bit forced 0 -> o_frame_err pulses 1 cycle, o_valid stays 0; then send 8'h11 -> o_data=8'h11.
REQ-038 Case 4 (FIFO_EN): send 8'h01..8'h05 back-to-back with i_ready=0 -> exactly one o_overrun pulse on 8'h05; then drain 8'h01..8'h04 in order.
REQ-039 Case 5 (no FIFO_EN): send 8'h01, 8'h02 with i_ready=0 -> o_overrun pulses on 8'h02 and o_data=8'h01.
REQ-040 Case 6: pull i_rst low during data bit 3 of 8'hFF -> all outputs return to reset values; the next clean frame 8'h42 is received correctly.
